// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: host command sequencer driving an ALU enable handshake
// over a 4-entry operand register file.
module alu_cmd_seq #(
    parameter int DWIDTH = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [2:0]        cmd_func,
    input  logic [1:0]        cmd_dst,
    input  logic [1:0]        cmd_srca,
    input  logic [1:0]        cmd_srcb,
    input  logic [DWIDTH-1:0] cmd_imm,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DWIDTH-1:0] resp_data,
    output logic              resp_err,
    output logic              alu_en,
    output logic [2:0]        alu_fn,
    output logic [DWIDTH-1:0] alu_opa,
    output logic [DWIDTH-1:0] alu_opb,
    input  logic [DWIDTH-1:0] alu_res,
    input  logic              alu_done
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam int CW = $clog2(TIMEOUT + 1);
    // WAIT lasts exactly TIMEOUT cycles, so the last count seen is TIMEOUT-1
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    state_t state;
    logic [DWIDTH-1:0] rf [4];
    logic [1:0] dst;
    logic [CW-1:0] cnt;
    assign cmd_ready = state == IDLE;
    assign resp_valid = state == RESP;
    assign alu_en = state == ISSUE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            for (int i = 0; i < 4; i++) rf[i] <= '0;
            dst <= '0;
            cnt <= '0;
            resp_data <= '0;
            resp_err <= 1'b0;
            alu_fn <= '0;
            alu_opa <= '0;
            alu_opb <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    resp_err <= 1'b0;
                    case (cmd_op)
                        2'b00: begin
                            rf[cmd_dst] <= cmd_imm;
                            resp_data <= cmd_imm;
                            state <= RESP;
                        end
                        2'b01: begin
                            alu_fn <= cmd_func;
                            alu_opa <= rf[cmd_srca];
                            alu_opb <= rf[cmd_srcb];
                            dst <= cmd_dst;
                            state <= ISSUE;
                        end
                        2'b10: begin
                            resp_data <= rf[cmd_srca];
                            state <= RESP;
                        end
                        default: begin
                            resp_err <= 1'b1;
                            resp_data <= '0;
                            state <= RESP;
                        end
                    endcase
                end
                ISSUE: begin
                    cnt <= '0;
                    state <= WAIT;
                end
                WAIT: if (alu_done) begin
                    rf[dst] <= alu_res;
                    resp_data <= alu_res;
                    resp_err <= 1'b0;
                    state <= RESP;
                end else if (cnt == LAST) begin
                    resp_err <= 1'b1;
                    resp_data <= '0;
                    state <= RESP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                RESP: if (resp_ready) state <= IDLE;
            endcase
        end
    end
endmodule
